// File: rtl/mult_hilo_seq_pkg.sv
// Shared constants for the HI/LO multiply sequencer: operand geometry and FSM encodings.
package mult_hilo_seq_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int HALF       = DATA_WIDTH / 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P0   = 3'd1;
  localparam logic [2:0] ST_P1   = 3'd2;
  localparam logic [2:0] ST_P2   = 3'd3;
  localparam logic [2:0] ST_P3   = 3'd4;
  localparam logic [2:0] ST_FIX  = 3'd5;

endpackage

// File: rtl/mult_hilo_seq_wallace.sv
// Combinational low-half multiplier: sums the partial-product array into a W-bit product.
module wallace_mult #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p + (a << i);
    end
  end

endmodule

// File: rtl/mult_hilo_seq.sv
// MULT/MULTU sequencer: four 16x16 passes through one shared multiplier build the
// 64-bit magnitude product, then a sign fix-up writes HI/LO.
module mult_hilo_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  input  logic                  flush,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  import mult_hilo_seq_pkg::*;

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic                  neg;
  logic [PROD_W-1:0]     acc;
  logic [HALF-1:0]       x;
  logic [HALF-1:0]       y;
  logic [DATA_WIDTH-1:0] p;
  logic [PROD_W-1:0]     p_ext;

  // -2^31 negates to itself, which read unsigned is the correct magnitude 0x80000000.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v,
                                                      input logic sgn);
    logic signed [DATA_WIDTH-1:0] r;
    r = (sgn && v[DATA_WIDTH-1]) ? -v : v;
    return r;
  endfunction

  function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign busy  = (state != ST_IDLE);
  assign p_ext = {{DATA_WIDTH{1'b0}}, p};

  always_comb begin
    x = a_mag[HALF-1:0];
    y = b_mag[HALF-1:0];
    case (state)
      ST_P1: y = b_mag[DATA_WIDTH-1:HALF];
      ST_P2: x = a_mag[DATA_WIDTH-1:HALF];
      ST_P3: begin
        x = a_mag[DATA_WIDTH-1:HALF];
        y = b_mag[DATA_WIDTH-1:HALF];
      end
      default: ;
    endcase
  end

  wallace_mult #(.W(DATA_WIDTH)) u_mult (
    .a ({{HALF{1'b0}}, x}),
    .b ({{HALF{1'b0}}, y}),
    .p (p)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            a_mag <= magnitude(opr_a, is_signed);
            b_mag <= magnitude(opr_b, is_signed);
            neg   <= is_signed & (opr_a[DATA_WIDTH-1] ^ opr_b[DATA_WIDTH-1]);
            state <= ST_P0;
          end
        end
        ST_P0: begin
          acc   <= p_ext;
          state <= flush ? ST_IDLE : ST_P1;
        end
        ST_P1: begin
          acc   <= acc + (p_ext << HALF);
          state <= flush ? ST_IDLE : ST_P2;
        end
        ST_P2: begin
          acc   <= acc + (p_ext << HALF);
          state <= flush ? ST_IDLE : ST_P3;
        end
        ST_P3: begin
          acc   <= acc + (p_ext << DATA_WIDTH);
          state <= flush ? ST_IDLE : ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!flush) begin
            {hi, lo} <= apply_sign(acc, neg);
            done     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_seq.sv
// Scoreboard bench for mult_hilo_seq: directed corner cases plus randomized MULT/MULTU traffic.
module tb_mult_hilo_seq;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, flush, hi_we, lo_we;
  logic [31:0] opr_a, opr_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mult_hilo_seq #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .opr_a     (opr_a),
    .opr_b     (opr_b),
    .flush     (flush),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle; leaves the bench in cycle 1 of the operation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit expect_result);
    opr_a     = a;
    opr_b     = b;
    is_signed = s;
    start     = 1'b1;
    if (expect_result) exp_q.push_back(ref_prod(a, b, s));
    step();
    start = 1'b0;
  endtask

  // Full operation with cycle-exact busy/done checks; returns in the done cycle.
  task automatic run_checked(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic s);
    issue(a, b, s, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("%s_busy_c%0d", name, c), busy, 1);
      check($sformatf("%s_done_c%0d", name, c), done, 0);
      step();
    end
    check({name, "_done_c6"}, done, 1);
    check({name, "_busy_c6"}, busy, 0);
    check({name, "_hilo"}, {hi, lo}, ref_prod(a, b, s));
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done with hi=0x%h lo=0x%h, required no done", hi, lo);
      end else begin
        check("scoreboard_result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; opr_a = '0; opr_b = '0; wdata = '0;
    step();
    step();
    reset = 1'b0;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    run_checked("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_checked("mult_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("mult_minmin_const", {hi, lo}, 64'h4000_0000_0000_0000);
    run_checked("mult_m1x1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check("mult_m1x1_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_checked("mult_7xm3", 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    check("mult_7xm3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_checked("back_to_back", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    step();
    check("done_low_after", done, 0);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", hi, 32'hA5A5_A5A5);
    check("mt_both_lo", lo, 32'hA5A5_A5A5);

    flush = 1'b1;
    issue(32'd5, 32'd6, 1'b0, 1'b0);
    flush = 1'b0;
    check("flush_start_idle_busy", busy, 0);

    // Flush mid-operation
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset2_hi", hi, 0);
    check("reset2_lo", lo, 0);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    step();
    hi_we = 1'b0;
    check("mthi", hi, 32'h1234_5678);
    issue(32'd2, 32'd3, 1'b0, 1'b0);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy_c4", busy, 0);
    check("flush_done_c4", done, 0);
    check("flush_hi", hi, 32'h1234_5678);
    check("flush_lo", lo, 0);
    repeat (3) step();
    check("flush_hi_later", hi, 32'h1234_5678);

    // MT write with start lands first; MT write while busy is dropped
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    issue(32'd3, 32'd4, 1'b0, 1'b1);
    hi_we = 1'b0;
    check("mt_with_start_hi", hi, 32'hDEAD_BEEF);
    lo_we = 1'b1; wdata = 32'h5555_AAAA;
    step();
    lo_we = 1'b0;
    check("mt_while_busy_lo", lo, 0);
    repeat (4) step();
    check("mt_start_result_done", done, 1);
    check("mt_start_result", {hi, lo}, 64'h0000_0000_0000_000C);

    // Start while busy is ignored
    step();
    issue(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
    opr_a = 32'd5; opr_b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("ignored_start_done", done, 1);
    check("ignored_start_result", {hi, lo}, 64'h0000_0001_0000_0000);
    step();
    check("ignored_start_busy_c7", busy, 0);

    // Reset mid-operation
    issue(32'd9, 32'd9, 1'b0, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    repeat (3) step();

    // Randomized back-to-back traffic
    for (int i = 0; i < 10000; i++) begin
      issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
      repeat (5) step();
    end
    repeat (3) step();

    check("queue_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
